// File: rtl/mult_hilo_ctrl.sv
// Sequencer for a combinational multiplier plus the architectural HI/LO register pair.
// Define MULT_CTRL_MADD_EN to enable the MADD/MADDU accumulate opcodes (110/111).
module mult_hilo_ctrl #(
  parameter int NR_OF_BITS   = 32,
  parameter int MULT_LATENCY = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  opValid,
  input  logic [2:0]            opCode,
  input  logic [NR_OF_BITS-1:0] opA,
  input  logic [NR_OF_BITS-1:0] opB,
  input  logic                  flush,
  output logic                  opReady,
  output logic [NR_OF_BITS-1:0] rdData,
  output logic                  rdValid,
  output logic                  busy,
  output logic [NR_OF_BITS-1:0] mulA,
  output logic [NR_OF_BITS-1:0] mulB,
  output logic                  mulSigned,
  output logic [NR_OF_BITS-1:0] mulCarryIn,
  input  logic [NR_OF_BITS-1:0] mulHigh,
  input  logic [NR_OF_BITS-1:0] mulLow,
  output logic [NR_OF_BITS-1:0] hi,
  output logic [NR_OF_BITS-1:0] lo
);
  localparam int N  = NR_OF_BITS;
  localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MULT_LATENCY - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [N-1:0]    mula_q, mula_d, mulb_q, mulb_d;
  logic [N-1:0]    rd_dat_q, rd_dat_d;
  logic            sgn_q, sgn_d, rd_vld_q, rd_vld_d;
  logic            accept;
  logic [2*N-1:0]  commit_val;
`ifdef MULT_CTRL_MADD_EN
  logic            acc_q, acc_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mula_d     = mula_q;
    mulb_d     = mulb_q;
    sgn_d      = sgn_q;
    rd_dat_d   = rd_dat_q;
    rd_vld_d   = 1'b0;
    opReady    = (state_q == IDLE);
    busy       = (state_q == RUN);
    accept     = opValid && (state_q == IDLE) && !flush;
`ifdef MULT_CTRL_MADD_EN
    acc_d      = acc_q;
    commit_val = acc_q ? ({hi_q, lo_q} + {mulHigh, mulLow}) : {mulHigh, mulLow};
`else
    commit_val = {mulHigh, mulLow};
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (opCode)
            3'b000, 3'b001: begin
              mula_d  = opA;
              mulb_d  = opB;
              sgn_d   = opCode[0];
              cnt_d   = CNT_INIT;
              state_d = RUN;
`ifdef MULT_CTRL_MADD_EN
              acc_d   = 1'b0;
`endif
            end
            3'b010: begin
              rd_dat_d = hi_q;
              rd_vld_d = 1'b1;
            end
            3'b011: begin
              rd_dat_d = lo_q;
              rd_vld_d = 1'b1;
            end
            3'b100: hi_d = opA;
            3'b101: lo_d = opA;
`ifdef MULT_CTRL_MADD_EN
            3'b110, 3'b111: begin
              mula_d  = opA;
              mulb_d  = opB;
              sgn_d   = opCode[0];
              cnt_d   = CNT_INIT;
              state_d = RUN;
              acc_d   = 1'b1;
            end
`endif
            // Without the accumulate option, 110/111 are consumed as no-ops.
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = commit_val;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mula_q   <= '0;
      mulb_q   <= '0;
      sgn_q    <= 1'b0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
`ifdef MULT_CTRL_MADD_EN
      acc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mula_q   <= mula_d;
      mulb_q   <= mulb_d;
      sgn_q    <= sgn_d;
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
`ifdef MULT_CTRL_MADD_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign mulA       = mula_q;
  assign mulB       = mulb_q;
  assign mulSigned  = sgn_q;
  assign mulCarryIn = '0;
  assign rdData     = rd_dat_q;
  assign rdValid    = rd_vld_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
